// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
//   On-chip burst-memory target that answers the arbiter's memory-request
//   protocol in place of sdram_controller. It is backed by an inferred RAM and
//   serves fixed-length read/write bursts with a programmable read latency.
//
// Optional feature:
//   SDRAM_BURST_RESP_CWF_EN - when defined, read bursts return the requested
//   word first and then wrap within the aligned block. When undefined, reads
//   start at the aligned block base. Writes are always aligned and ascending.
//
// Ports:
//   i_Clk          clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Addr         burst word address, sampled when a request is accepted
//   i_Req_Valid    request present; held by the initiator until o_Last
//   i_Read_Write_n 1 = read burst, 0 = write burst; sampled on acceptance
//   i_Data         write word, captured at the edge ending each o_Data_Read cycle
//   o_Data_Read    write beat consumed this cycle
//   o_Data         registered read word; holds its value between beats
//   o_Data_Valid   o_Data carries a read beat this cycle
//   o_Last         final beat of the current burst
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and i_Req_Valid=1. There is no back-pressure in either direction after
// acceptance: read beats are pushed on consecutive cycles and write beats are
// pulled on consecutive cycles; the initiator must keep up. The FSM state is
// held in the internal signal `state` for checkers to observe.
module sdram_burst_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 22,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int BURST_LEN      = 8,
  parameter int READ_LATENCY   = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [ADDRESS_WIDTH-1:0] i_Addr,
  input  logic                     i_Req_Valid,
  input  logic                     i_Read_Write_n,
  input  logic [DATA_WIDTH-1:0]    i_Data,
  output logic                     o_Data_Read,
  output logic [DATA_WIDTH-1:0]    o_Data,
  output logic                     o_Data_Valid,
  output logic                     o_Last
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  // RLAT is left at the edge that moves into RBURST, one edge before the first
  // read beat is registered, so it counts READ_LATENCY-1 edges.
  localparam logic [LAT_W-1:0]  LAT_END     = (READ_LATENCY > 1) ? LAT_W'(READ_LATENCY - 2) : '0;
  localparam logic [BEAT_W-1:0] BEAT_END    = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_PENULT = BEAT_W'(BURST_LEN - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RLAT    = 3'd1,
    RBURST  = 3'd2,
    WBURST  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t                    state;
  logic [MEM_DEPTH_LOG2-1:0] base;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [LAT_W-1:0]          lat_cnt;

  logic [DATA_WIDTH-1:0]     mem [0:(2**MEM_DEPTH_LOG2)-1];

  logic [BEAT_W-1:0]         rd_offset;
  logic [MEM_DEPTH_LOG2-1:0] rd_addr;
  logic [MEM_DEPTH_LOG2-1:0] wr_addr;

  // Address bits above the RAM depth alias onto the same words.
  logic unused_bits;
  assign unused_bits = ^{i_Addr[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2], base[BEAT_W-1:0]};

`ifdef SDRAM_BURST_RESP_CWF_EN
  // Critical word first: modulo-BURST_LEN add wraps inside the aligned block.
  assign rd_offset = base[BEAT_W-1:0] + beat_cnt;
`else
  assign rd_offset = beat_cnt;
`endif

  assign rd_addr = {base[MEM_DEPTH_LOG2-1:BEAT_W], rd_offset};
  assign wr_addr = {base[MEM_DEPTH_LOG2-1:BEAT_W], beat_cnt};

  // RAM write port. o_Data_Read is cleared asynchronously by reset, so a beat
  // interrupted by reset is never written.
  always_ff @(posedge i_Clk) begin
    if (o_Data_Read) begin
      mem[wr_addr] <= i_Data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      base         <= '0;
      beat_cnt     <= '0;
      lat_cnt      <= '0;
      o_Data_Read  <= 1'b0;
      o_Data       <= '0;
      o_Data_Valid <= 1'b0;
      o_Last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Req_Valid) begin
            base     <= i_Addr[MEM_DEPTH_LOG2-1:0];
            beat_cnt <= '0;
            lat_cnt  <= '0;
            if (i_Read_Write_n) begin
              state <= (READ_LATENCY == 1) ? RBURST : RLAT;
            end else begin
              state <= WBURST;
            end
          end
        end

        RLAT: begin
          if (lat_cnt == LAT_END) begin
            state <= RBURST;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        RBURST: begin
          // o_Last high means the final beat is on the bus now; this edge ends it.
          if (o_Last) begin
            o_Data_Valid <= 1'b0;
            o_Last       <= 1'b0;
            state        <= RECOVER;
          end else begin
            o_Data_Valid <= 1'b1;
            o_Data       <= mem[rd_addr];
            o_Last       <= (beat_cnt == BEAT_END);
            beat_cnt     <= beat_cnt + BEAT_W'(1);
          end
        end

        WBURST: begin
          // The first WBURST edge only raises o_Data_Read; each later edge
          // consumes the beat presented during the cycle it ends.
          if (o_Data_Read) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
          if (o_Last) begin
            o_Data_Read <= 1'b0;
            o_Last      <= 1'b0;
            state       <= RECOVER;
          end else begin
            o_Data_Read <= 1'b1;
            o_Last      <= o_Data_Read && (beat_cnt == BEAT_PENULT);
          end
        end

        RECOVER: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_responder.sv
module tb_sdram_burst_responder;
  localparam int DW = 32;
  localparam int AW = 22;
  localparam int ML = 12;
  localparam int BL = 8;
  localparam int RL = 3;
  localparam int DEPTH = 1 << ML;

  // ---------------- clock / reset / DUT ----------------
  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic [AW-1:0] i_Addr;
  logic          i_Req_Valid;
  logic          i_Read_Write_n;
  logic [DW-1:0] i_Data;
  logic          o_Data_Read;
  logic [DW-1:0] o_Data;
  logic          o_Data_Valid;
  logic          o_Last;

  always #5 i_Clk = ~i_Clk;

  sdram_burst_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH_LOG2(ML),
    .BURST_LEN(BL), .READ_LATENCY(RL)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Addr(i_Addr),
    .i_Req_Valid(i_Req_Valid), .i_Read_Write_n(i_Read_Write_n),
    .i_Data(i_Data), .o_Data_Read(o_Data_Read), .o_Data(o_Data),
    .o_Data_Valid(o_Data_Valid), .o_Last(o_Last)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            known   [0:DEPTH-1];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int read_beat_addr(input int base, input int k);
    int blk;
    blk = base - (base % BL);
`ifdef SDRAM_BURST_RESP_CWF_EN
    return blk + ((base + k) % BL);
`else
    return blk + k;
`endif
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, DW'(o_Data_Valid), '0);
    chk({tag, ".dread"}, DW'(o_Data_Read), '0);
    chk({tag, ".last"},  DW'(o_Last), '0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_quiet(tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Write burst with data d0+k; abort_beat >= 0 pulses reset while that beat
  // (0-based) is on the bus.
  task automatic write_burst(input logic [AW-1:0] addr, input logic [DW-1:0] d0,
                             input int abort_beat);
    int base, aligned;
    bit exp_dr, exp_last;
    base    = int'(addr[ML-1:0]);
    aligned = base - (base % BL);
    i_Addr = addr; i_Read_Write_n = 1'b0; i_Req_Valid = 1'b1;
    tick();                                       // acceptance edge E0
    chk("wr.e0.dread", DW'(o_Data_Read), '0);
    i_Addr = $urandom; i_Read_Write_n = 1'b1;     // must be ignored after acceptance
    for (int rel = 1; rel <= BL + 1; rel++) begin
      tick();
      exp_dr   = (rel <= BL);
      exp_last = (rel == BL);
      chk("wr.dread", DW'(o_Data_Read), DW'(exp_dr));
      chk("wr.last",  DW'(o_Last),      DW'(exp_last));
      chk("wr.valid", DW'(o_Data_Valid), '0);
      if (exp_dr) begin
        i_Data = d0 + DW'(rel - 1);
        if (rel - 1 == abort_beat) begin
          #2 i_Reset = 1'b1;
          #1;
          chk_quiet("wr.abort");
          chk("wr.abort.data", o_Data, '0);
          @(posedge i_Clk);
          #1;
          i_Reset = 1'b0; i_Req_Valid = 1'b0;
          idle_cycles(2, "wr.abort.idle");
          return;
        end
        ref_mem[aligned + rel - 1] = i_Data;
        known[aligned + rel - 1]   = 1'b1;
      end
      if (exp_last) i_Req_Valid = 1'b0;
    end
    idle_cycles(2, "wr.recover");
  endtask

  task automatic read_burst(input logic [AW-1:0] addr);
    int base, k, a;
    bit exp_dv, exp_last, last_known;
    logic [DW-1:0] last_d;
    base = int'(addr[ML-1:0]);
    last_known = 1'b0;
    last_d = '0;
    i_Addr = addr; i_Read_Write_n = 1'b1; i_Req_Valid = 1'b1;
    tick();                                       // acceptance edge E0
    chk("rd.e0.valid", DW'(o_Data_Valid), '0);
    i_Addr = $urandom; i_Read_Write_n = 1'b0;
    for (int rel = 1; rel <= RL + BL; rel++) begin
      tick();
      k        = rel - RL;
      exp_dv   = (k >= 0) && (k < BL);
      exp_last = (k == BL - 1);
      chk("rd.valid", DW'(o_Data_Valid), DW'(exp_dv));
      chk("rd.last",  DW'(o_Last),       DW'(exp_last));
      chk("rd.dread", DW'(o_Data_Read),  '0);
      if (exp_dv) begin
        a = read_beat_addr(base, k);
        last_known = known[a];
        last_d     = ref_mem[a];
        if (known[a]) chk($sformatf("rd.data[%0d]", k), o_Data, ref_mem[a]);
      end else if (k == BL && last_known) begin
        chk("rd.hold", o_Data, last_d);
      end
      if (exp_last) i_Req_Valid = 1'b0;
    end
    idle_cycles(2, "rd.recover");
  endtask

  // ---------------- directed + random sequence ----------------
  int blocks [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    i_Reset = 1'b1; i_Addr = '0; i_Req_Valid = 1'b0; i_Read_Write_n = 1'b0; i_Data = '0;

    // reset held 3 cycles, then quiet with no requests
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("reset");
      chk("reset.data", o_Data, '0);
    end
    i_Reset = 1'b0;
    idle_cycles(20, "post_reset");

    // basic write / read, unaligned read, alias, mid-burst reset
    write_burst(22'h000010, 32'hA0, -1);
    read_burst(22'h000010);
    read_burst(22'h000013);
    write_burst(22'h001010, 32'hB0, -1);
    read_burst(22'h000010);
    write_burst(22'h000020, 32'hC0, 3);
    read_burst(22'h000020);

    // randomized traffic over a few blocks with random aliasing bits
    for (int b = 0; b < 4; b++) begin
      blocks[b] = $urandom_range(8, DEPTH / BL - 1) * BL;
      write_burst({AW'($urandom_range(0, 1023)) << ML} | AW'(blocks[b] + $urandom_range(0, BL - 1)),
                  $urandom, -1);
    end
    for (int n = 0; n < 12; n++) begin
      int b;
      logic [AW-1:0] addr;
      b = $urandom_range(0, 3);
      addr = (AW'($urandom_range(0, 1023)) << ML) | AW'(blocks[b] + $urandom_range(0, BL - 1));
      if ($urandom_range(0, 1) == 1) read_burst(addr);
      else write_burst(addr, $urandom, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
